bus_router: RTL and testbench
=============================

BUS_ROUTER -- requirements
Module: bus_router

Interface
REQ-001 SHALL have parameter NDEV, default 4: number of device regions, range 1..8.
REQ-002 SHALL have parameter BASES, default {32'h30000000,32'h20000000,32'h10000000,32'h00000000}: packed NDEV x 32-bit region bases; region i occupies bits [32*i+31:32*i].
REQ-003 SHALL have parameter MASKS, default {8'd12,8'd12,8'd8,8'd16}: packed NDEV x 8-bit region sizes as log2 bytes; region i occupies bits [8*i+7:8*i]; each value is in 0..31.
REQ-004 SHALL have parameter TIMEOUT, default 255: wait-cycle limit; 0 disables the timeout.
REQ-005 SHALL have ports:
  clk        in   1        clock, rising edge
  n_rst      in   1        reset, synchronous, active-low
  req        in   1        master request strobe, sampled in IDLE only
  addr       in   32       master byte address
  we         in   1        1 = write, 0 = read
  wdata      in   32       master write data
  ack        out  1        one-cycle pulse: access completed
  err        out  1        one-cycle pulse: unmapped address or timeout
  rdata      out  32       read data, valid while ack = 1 on a read
  busy       out  1        transaction in progress
  dev_en     out  NDEV     one-hot device select
  dev_addr   out  32       offset within the selected region
  dev_we     out  1        forwarded we
  dev_wdata  out  32       forwarded wdata
  dev_rdata  in   32*NDEV  device read data; slice i = device i
  dev_ready  in   NDEV     device completion; bit i = device i

Function
REQ-006 Region i SHALL match when addr[31:MASKS_i] == BASES_i[31:MASKS_i]; if MASKS_i = 0, all 32 bits are compared.
REQ-007 When several regions match, the lowest index SHALL win.
REQ-008 dev_addr SHALL equal addr - BASES_sel, computed modulo 2^32.
REQ-009 The FSM SHALL have the states IDLE, ACCESS and RESP.
REQ-010 IDLE with req = 1 and a match SHALL register dev_en = one-hot(sel), dev_addr, dev_we and dev_wdata, set busy = 1, and enter ACCESS.
REQ-011 IDLE with req = 1 and no match SHALL enter RESP with err = 1 and busy = 1; dev_en SHALL stay 0.
REQ-012 In ACCESS, dev_en, dev_addr, dev_we and dev_wdata SHALL hold constant.
REQ-013 In ACCESS, the bus SHALL inspect only dev_ready[sel] and dev_rdata[sel]; all other bits are ignored.
REQ-014 In ACCESS with dev_ready[sel] = 1, the bus SHALL clear dev_en, capture rdata = dev_rdata[sel] (reads only), set ack = 1 and enter RESP.
REQ-015 In ACCESS, a wait counter SHALL increment every cycle that dev_ready[sel] = 0.
REQ-016 When the wait counter reaches TIMEOUT (TIMEOUT > 0), the bus SHALL clear dev_en, set err = 1 and enter RESP.
REQ-017 If dev_ready[sel] = 1 on the same cycle the counter reaches TIMEOUT, ready SHALL win: ack = 1, err = 0.
REQ-018 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide, minimum 1 bit, and SHALL clear on entry to ACCESS.
REQ-019 RESP SHALL last exactly one cycle, then clear ack, err and busy and return to IDLE.
REQ-020 req SHALL be ignored outside IDLE; a new request is accepted no earlier than the cycle after RESP.
REQ-021 Latency SHALL be: req sampled at edge 0; dev_en high from edge 1; dev_ready seen at edge k >= 1 gives ack high in the cycle after edge k.
REQ-022 rdata SHALL change only on read completion; writes and errors SHALL leave it unchanged.
REQ-023 ack and err SHALL never be high together, and dev_en SHALL have at most one bit set.

Reset
REQ-024 With n_rst = 0 at a clock edge, the FSM SHALL enter IDLE and the wait counter SHALL clear.
REQ-025 Reset SHALL force ack, err, busy, dev_en, dev_we, dev_addr, dev_wdata and rdata to 0.
REQ-026 Reset mid-ACCESS SHALL abort the access with no ack and no err.
REQ-027 Reset SHALL take priority over all other events on the same edge.

Verification
REQ-028 Default parameters; read of addr 0x10000044, dev_ready[1] high at edge 3 with dev_rdata[1] = 0xCAFEF00D -> dev_en = 4'b0010, dev_addr = 0x44, ack and rdata = 0xCAFEF00D in the cycle after edge 3.
REQ-029 Read of addr 0x40000000 (unmapped) -> err = 1 for one cycle after edge 0, dev_en = 0 throughout, rdata unchanged.
REQ-030 TIMEOUT = 4; write to 0x20000010 with dev_ready low -> err pulse after exactly 4 wait cycles, then dev_en = 0 and busy = 0.
REQ-031 TIMEOUT = 4; dev_ready[2] high on the same cycle as count 4 -> ack = 1, err = 0.
REQ-032 Overlapping bases (region 0 = 0x0, MASKS_0 = 31; region 1 = 0x0, MASKS_1 = 12) with addr 0x100 -> region 0 selected; second req asserted while busy is ignored.
REQ-033 n_rst low during ACCESS -> next cycle all outputs 0, no ack or err pulse; a fresh req afterwards completes normally.

Source files
------------

// File: rtl/bus_router.sv
// Single-master bus router: decodes the master address into one of NDEV regions,
// forwards the access to that device and waits for its ready or a timeout.

module bus_router_region #(
    parameter logic [31:0] BASE   = 32'h0,
    parameter logic [7:0]  LOG2SZ = 8'd0
) (
    input  logic [31:0] addr_i,
    output logic        match_o
);
    // A size of 0 leaves every bit in KEEP, i.e. an exact 32-bit compare.
    localparam logic [31:0] KEEP = 32'hFFFF_FFFF << LOG2SZ[4:0];

    assign match_o = ((addr_i ^ BASE) & KEEP) == 32'd0;
endmodule

module bus_router #(
    parameter int                 NDEV    = 4,
    parameter logic [32*NDEV-1:0] BASES   = {32'h30000000, 32'h20000000, 32'h10000000, 32'h00000000},
    parameter logic [8*NDEV-1:0]  MASKS   = {8'd12, 8'd12, 8'd8, 8'd16},
    parameter int                 TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 req,
    input  logic [31:0]          addr,
    input  logic                 we,
    input  logic [31:0]          wdata,
    output logic                 ack,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic                 busy,
    output logic [NDEV-1:0]      dev_en,
    output logic [31:0]          dev_addr,
    output logic                 dev_we,
    output logic [31:0]          dev_wdata,
    input  logic [32*NDEV-1:0]   dev_rdata,
    input  logic [NDEV-1:0]      dev_ready
);
    localparam int SW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int CW = (TIMEOUT > 0) ? (($clog2(TIMEOUT + 1) > 0) ? $clog2(TIMEOUT + 1) : 1) : 1;
    localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ack_q, ack_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;
    logic [NDEV-1:0] dev_en_q, dev_en_d;
    logic [31:0]     dev_addr_q, dev_addr_d;
    logic            dev_we_q, dev_we_d;
    logic [31:0]     dev_wdata_q, dev_wdata_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [NDEV-1:0] match;
    logic            hit;
    logic [SW-1:0]   hit_sel;
    logic [NDEV-1:0] hit_oh;
    logic [31:0]     base_sel;
    logic            rdy_sel;
    logic [31:0]     rdata_sel;

    for (genvar g = 0; g < NDEV; g++) begin : g_rgn
        bus_router_region #(
            .BASE   (BASES[32*g +: 32]),
            .LOG2SZ (MASKS[8*g +: 8])
        ) u_rgn (
            .addr_i  (addr),
            .match_o (match[g])
        );
    end

    // Scan high to low so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_sel = '0;
        hit_oh  = '0;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit       = 1'b1;
                hit_sel   = SW'(i);
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        base_sel  = '0;
        rdy_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NDEV; i++) begin
            if (hit_sel == SW'(i)) base_sel = BASES[32*i +: 32];
            if (sel_q == SW'(i)) begin
                rdy_sel   = dev_ready[i];
                rdata_sel = dev_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        busy_d      = busy_q;
        dev_en_d    = dev_en_q;
        dev_addr_d  = dev_addr_q;
        dev_we_d    = dev_we_q;
        dev_wdata_d = dev_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    busy_d = 1'b1;
                    if (hit) begin
                        sel_d       = hit_sel;
                        cnt_d       = '0;
                        dev_en_d    = hit_oh;
                        dev_addr_d  = addr - base_sel;
                        dev_we_d    = we;
                        dev_wdata_d = wdata;
                        state_d     = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked first so it wins over a simultaneous timeout.
                if (rdy_sel) begin
                    dev_en_d = '0;
                    ack_d    = 1'b1;
                    if (!dev_we_q) rdata_d = rdata_sel;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (TIMEOUT > 0 && cnt_d == TO_CNT) begin
                        dev_en_d = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            dev_en_q    <= '0;
            dev_addr_q  <= '0;
            dev_we_q    <= 1'b0;
            dev_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            dev_en_q    <= dev_en_d;
            dev_addr_q  <= dev_addr_d;
            dev_we_q    <= dev_we_d;
            dev_wdata_q <= dev_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign dev_en    = dev_en_q;
    assign dev_addr  = dev_addr_q;
    assign dev_we    = dev_we_q;
    assign dev_wdata = dev_wdata_q;
endmodule

// File: tb/tb_bus_router.sv
// Directed bench: three router instances (default map, short timeout, overlapping regions).

module tb_bus_router;
    logic clk = 1'b0;
    logic n_rst;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // u0: default parameters
    logic req0, we0, ack0, err0, busy0, dwe0;
    logic [31:0] addr0, wdata0, rdata0, daddr0, dwdata0;
    logic [3:0] den0, drdy0;
    logic [127:0] drdata0;
    // u1: TIMEOUT = 4
    logic req1, we1, ack1, err1, busy1, dwe1;
    logic [31:0] addr1, wdata1, rdata1, daddr1, dwdata1;
    logic [3:0] den1, drdy1;
    logic [127:0] drdata1;
    // u2: two overlapping regions at base 0
    logic req2, we2, ack2, err2, busy2, dwe2;
    logic [31:0] addr2, wdata2, rdata2, daddr2, dwdata2;
    logic [1:0] den2, drdy2;
    logic [63:0] drdata2;

    bus_router u0 (
        .clk(clk), .n_rst(n_rst), .req(req0), .addr(addr0), .we(we0), .wdata(wdata0),
        .ack(ack0), .err(err0), .rdata(rdata0), .busy(busy0), .dev_en(den0),
        .dev_addr(daddr0), .dev_we(dwe0), .dev_wdata(dwdata0),
        .dev_rdata(drdata0), .dev_ready(drdy0)
    );

    bus_router #(.TIMEOUT(4)) u1 (
        .clk(clk), .n_rst(n_rst), .req(req1), .addr(addr1), .we(we1), .wdata(wdata1),
        .ack(ack1), .err(err1), .rdata(rdata1), .busy(busy1), .dev_en(den1),
        .dev_addr(daddr1), .dev_we(dwe1), .dev_wdata(dwdata1),
        .dev_rdata(drdata1), .dev_ready(drdy1)
    );

    bus_router #(
        .NDEV(2),
        .BASES({32'h00000000, 32'h00000000}),
        .MASKS({8'd12, 8'd31})
    ) u2 (
        .clk(clk), .n_rst(n_rst), .req(req2), .addr(addr2), .we(we2), .wdata(wdata2),
        .ack(ack2), .err(err2), .rdata(rdata2), .busy(busy2), .dev_en(den2),
        .dev_addr(daddr2), .dev_we(dwe2), .dev_wdata(dwdata2),
        .dev_rdata(drdata2), .dev_ready(drdy2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_rst = 1'b0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; drdy0 = 0; drdata0 = '0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; drdy1 = 0; drdata1 = '0;
        req2 = 0; we2 = 0; addr2 = 0; wdata2 = 0; drdy2 = 0; drdata2 = '0;
        tick(); tick();
        chk("rst_ack", {31'd0, ack0}, 32'd0);
        chk("rst_err", {31'd0, err0}, 32'd0);
        chk("rst_busy", {31'd0, busy0}, 32'd0);
        chk("rst_den", {28'd0, den0}, 32'd0);
        chk("rst_rdata", rdata0, 32'd0);
        chk("rst_daddr", daddr0, 32'd0);
        chk("rst_den2", {30'd0, den2}, 32'd0);
        n_rst = 1'b1;
        tick();

        // Read from region 1; other devices shout ready but must be ignored.
        req0 = 1; we0 = 0; addr0 = 32'h10000044;
        drdata0 = {32'h33333333, 32'h22222222, 32'hCAFEF00D, 32'h00000000};
        drdy0 = 4'b1001;
        tick();                                   // edge 0
        req0 = 0;
        chk("rd_den", {28'd0, den0}, 32'h2);
        chk("rd_daddr", daddr0, 32'h44);
        chk("rd_busy", {31'd0, busy0}, 32'd1);
        chk("rd_ack_early", {31'd0, ack0}, 32'd0);
        tick();                                   // edge 1
        chk("rd_den_hold", {28'd0, den0}, 32'h2);
        chk("rd_ack_e1", {31'd0, ack0}, 32'd0);
        tick();                                   // edge 2
        drdy0 = 4'b0010;
        tick();                                   // edge 3
        chk("rd_ack", {31'd0, ack0}, 32'd1);
        chk("rd_err", {31'd0, err0}, 32'd0);
        chk("rd_rdata", rdata0, 32'hCAFEF00D);
        chk("rd_den_clr", {28'd0, den0}, 32'd0);
        drdy0 = 0;
        tick();
        chk("rd_ack_pulse", {31'd0, ack0}, 32'd0);
        chk("rd_busy_clr", {31'd0, busy0}, 32'd0);

        // Unmapped address.
        req0 = 1; addr0 = 32'h40000000;
        tick();
        req0 = 0;
        chk("um_err", {31'd0, err0}, 32'd1);
        chk("um_ack", {31'd0, ack0}, 32'd0);
        chk("um_den", {28'd0, den0}, 32'd0);
        chk("um_busy", {31'd0, busy0}, 32'd1);
        chk("um_rdata", rdata0, 32'hCAFEF00D);
        tick();
        chk("um_err_pulse", {31'd0, err0}, 32'd0);
        chk("um_busy_clr", {31'd0, busy0}, 32'd0);

        // Write to region 3 must not disturb rdata.
        req0 = 1; we0 = 1; addr0 = 32'h30000ABC; wdata0 = 32'h12345678;
        tick();
        req0 = 0;
        chk("wr_den", {28'd0, den0}, 32'h8);
        chk("wr_daddr", daddr0, 32'hABC);
        chk("wr_dwe", {31'd0, dwe0}, 32'd1);
        chk("wr_dwdata", dwdata0, 32'h12345678);
        drdata0[127:96] = 32'hDEADBEEF;
        drdy0 = 4'b1000;
        tick();
        drdy0 = 0;
        chk("wr_ack", {31'd0, ack0}, 32'd1);
        chk("wr_rdata", rdata0, 32'hCAFEF00D);
        tick();

        // Timeout after exactly four wait cycles.
        req1 = 1; we1 = 1; addr1 = 32'h20000010; wdata1 = 32'hA5A5A5A5;
        tick();                                   // edge 0
        req1 = 0;
        chk("to_den", {28'd0, den1}, 32'h4);
        chk("to_daddr", daddr1, 32'h10);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("to_wait_den", {28'd0, den1}, 32'h4);
            chk("to_wait_err", {31'd0, err1}, 32'd0);
        end
        tick();                                   // edge 4
        chk("to_err", {31'd0, err1}, 32'd1);
        chk("to_ack", {31'd0, ack1}, 32'd0);
        chk("to_den_clr", {28'd0, den1}, 32'd0);
        tick();
        chk("to_err_pulse", {31'd0, err1}, 32'd0);
        chk("to_busy_clr", {31'd0, busy1}, 32'd0);
        chk("to_den_idle", {28'd0, den1}, 32'd0);

        // Ready on the same cycle the counter would hit the limit.
        req1 = 1; we1 = 0; addr1 = 32'h20000020;
        tick();                                   // edge 0
        req1 = 0;
        tick(); tick(); tick();                   // edges 1..3
        drdata1[95:64] = 32'h0BADCAFE;
        drdy1 = 4'b0100;
        tick();                                   // edge 4
        drdy1 = 0;
        chk("race_ack", {31'd0, ack1}, 32'd1);
        chk("race_err", {31'd0, err1}, 32'd0);
        chk("race_rdata", rdata1, 32'h0BADCAFE);
        tick();
        chk("race_ack_pulse", {31'd0, ack1}, 32'd0);

        // Overlapping regions: lowest index wins; req held through busy is ignored.
        req2 = 1; we2 = 0; addr2 = 32'h00000100;
        tick();                                   // edge 0
        addr2 = 32'h00000200;
        chk("ov_den", {30'd0, den2}, 32'h1);
        chk("ov_daddr", daddr2, 32'h100);
        tick();                                   // edge 1
        chk("ov_den_hold", {30'd0, den2}, 32'h1);
        chk("ov_daddr_hold", daddr2, 32'h100);
        drdata2 = {32'h99999999, 32'h11112222};
        drdy2 = 2'b01;
        tick();                                   // edge 2
        drdy2 = 0;
        chk("ov_ack", {31'd0, ack2}, 32'd1);
        chk("ov_rdata", rdata2, 32'h11112222);
        tick();                                   // edge 3, RESP ignores req
        chk("ov_busy_resp", {31'd0, busy2}, 32'd0);
        chk("ov_den_resp", {30'd0, den2}, 32'd0);
        req2 = 0;
        tick();
        chk("ov_idle_busy", {31'd0, busy2}, 32'd0);
        chk("ov_idle_den", {30'd0, den2}, 32'd0);

        // Reset in the middle of an access, with ready asserted on that edge.
        req0 = 1; we0 = 0; addr0 = 32'h10000080;
        tick();
        req0 = 0;
        chk("ra_den", {28'd0, den0}, 32'h2);
        tick();
        n_rst = 0;
        drdy0 = 4'b0010;
        tick();
        chk("ra_ack", {31'd0, ack0}, 32'd0);
        chk("ra_err", {31'd0, err0}, 32'd0);
        chk("ra_busy", {31'd0, busy0}, 32'd0);
        chk("ra_den", {28'd0, den0}, 32'd0);
        chk("ra_daddr", daddr0, 32'd0);
        chk("ra_dwe", {31'd0, dwe0}, 32'd0);
        chk("ra_dwdata", dwdata0, 32'd0);
        chk("ra_rdata", rdata0, 32'd0);
        n_rst = 1;
        drdy0 = 0;
        tick();
        chk("ra_ack_after", {31'd0, ack0}, 32'd0);
        chk("ra_err_after", {31'd0, err0}, 32'd0);
        req0 = 1; we0 = 1; addr0 = 32'h00001234; wdata0 = 32'h55AA55AA;
        tick();
        req0 = 0;
        chk("fr_den", {28'd0, den0}, 32'h1);
        chk("fr_daddr", daddr0, 32'h1234);
        chk("fr_dwdata", dwdata0, 32'h55AA55AA);
        drdy0 = 4'b0001;
        tick();
        drdy0 = 0;
        chk("fr_ack", {31'd0, ack0}, 32'd1);
        chk("fr_rdata", rdata0, 32'd0);
        tick();
        chk("fr_busy_clr", {31'd0, busy0}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
